acs_butterfly: RTL and testbench

Radix-2 add-compare-select butterfly for the 64-state, rate-1/2 hard-decision Viterbi decoder. It sits directly downstream of the per-transition branch-metric units, which produce 2-bit Hamming distances. For predecessor states 2j and 2j+1 it registers the surviving path metrics for successor states j and j+32, and emits one decision bit per successor to the traceback memory. The block is fully pipelined, accepts one trellis step per cycle, and has no backpressure.

---
 rtl/viterbi_pkg.sv | 14 +
 rtl/acs_butterfly_if.sv | 36 +++
 rtl/acs_node.sv | 50 +++++
 rtl/acs_butterfly.sv | 89 ++++++++
 tb/tb_acs_butterfly.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared widths and initial-metric constants for the 64-state, rate-1/2 Viterbi ACS datapath.
package viterbi_pkg;

  localparam int PM_W_DEFAULT = 8;
  localparam int BM_W         = 2;
  localparam int NUM_STATES   = 64;
  localparam int INIT_HIGH    = 1 << (PM_W_DEFAULT - 2);

  // Starting metric for states other than 0; leaves headroom below the MSB.
  function automatic int init_high(input int pm_w);
    return 1 << (pm_w - 2);
  endfunction

endpackage

// File: rtl/acs_butterfly_if.sv
// Trellis-step inputs and registered survivor outputs of one radix-2 ACS butterfly.
interface acs_butterfly_if
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEFAULT
);

  logic            in_valid;
  logic            frame_start;
  logic            norm_req;
  logic [PM_W-1:0] pm_in_a;
  logic [PM_W-1:0] pm_in_b;
  logic [BM_W-1:0] bm_a0;
  logic [BM_W-1:0] bm_b0;
  logic [BM_W-1:0] bm_a1;
  logic [BM_W-1:0] bm_b1;
  logic [PM_W-1:0] pm_out_0;
  logic [PM_W-1:0] pm_out_1;
  logic            dec_0;
  logic            dec_1;
  logic            out_valid;
  logic            pm_msb_and;

  modport master (
    output in_valid, frame_start, norm_req, pm_in_a, pm_in_b,
           bm_a0, bm_b0, bm_a1, bm_b1,
    input  pm_out_0, pm_out_1, dec_0, dec_1, out_valid, pm_msb_and
  );

  modport slave (
    input  in_valid, frame_start, norm_req, pm_in_a, pm_in_b,
           bm_a0, bm_b0, bm_a1, bm_b1,
    output pm_out_0, pm_out_1, dec_0, dec_1, out_valid, pm_msb_and
  );

endinterface

// File: rtl/acs_node.sv
// Combinational add-compare-select for one successor state.
// ACS_NORM_EN selects saturating adds, unsigned compare and MSB normalization; otherwise modular metrics.
module acs_node
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEFAULT
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [BM_W-1:0] bm_a,
  input  logic [BM_W-1:0] bm_b,
  input  logic            norm_req,
  output logic [PM_W-1:0] pm_sel,
  output logic            dec
);

`ifdef ACS_NORM_EN
  localparam logic [PM_W-1:0] NORM_SUB = {1'b1, {(PM_W-1){1'b0}}};

  logic [PM_W:0]   sum_a;
  logic [PM_W:0]   sum_b;
  logic [PM_W-1:0] cand_a;
  logic [PM_W-1:0] cand_b;
  logic [PM_W-1:0] sel_raw;

  assign sum_a   = {1'b0, pm_a} + (PM_W+1)'(bm_a);
  assign sum_b   = {1'b0, pm_b} + (PM_W+1)'(bm_b);
  assign cand_a  = sum_a[PM_W] ? '1 : sum_a[PM_W-1:0];
  assign cand_b  = sum_b[PM_W] ? '1 : sum_b[PM_W-1:0];
  // Strict less-than so a tie keeps the 2j path.
  assign dec     = (cand_b < cand_a);
  assign sel_raw = dec ? cand_b : cand_a;
  // Controller only requests this when every metric has its MSB set, so no underflow.
  assign pm_sel  = norm_req ? (sel_raw - NORM_SUB) : sel_raw;
`else
  logic [PM_W-1:0] cand_a;
  logic [PM_W-1:0] cand_b;
  logic [PM_W-1:0] diff;
  logic            unused_norm;

  assign unused_norm = norm_req;
  assign cand_a = pm_a + PM_W'(bm_a);
  assign cand_b = pm_b + PM_W'(bm_b);
  // Modular compare: A < B when the wrapped difference is negative; equal keeps A.
  assign diff   = cand_a - cand_b;
  assign dec    = ~diff[PM_W-1] & (diff != '0);
  assign pm_sel = dec ? cand_b : cand_a;
`endif

endmodule

// File: rtl/acs_butterfly.sv
// Radix-2 ACS butterfly: registers survivor metrics for successors j and j+32 plus decision bits.
// Optional macro ACS_NORM_EN enables saturating metrics with global MSB normalization.
module acs_butterfly
  import viterbi_pkg::*;
#(
  parameter int PM_W      = PM_W_DEFAULT,
  parameter bit IS_STATE0 = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  acs_butterfly_if.slave bus
);

  localparam logic [PM_W-1:0] INIT_PM1 = PM_W'(init_high(PM_W));
  localparam logic [PM_W-1:0] INIT_PM0 = IS_STATE0 ? '0 : INIT_PM1;

  logic [BM_W-1:0] bm_a_arr [2];
  logic [BM_W-1:0] bm_b_arr [2];
  logic [PM_W-1:0] pm_sel   [2];
  logic            dec_sel  [2];

  logic [PM_W-1:0] pm_reg   [2];
  logic [PM_W-1:0] pm_next  [2];
  logic            dec_reg  [2];
  logic            dec_next [2];
  logic            valid_reg;
  logic            valid_next;

  assign bm_a_arr[0] = bus.bm_a0;
  assign bm_b_arr[0] = bus.bm_b0;
  assign bm_a_arr[1] = bus.bm_a1;
  assign bm_b_arr[1] = bus.bm_b1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_node
      acs_node #(
        .PM_W(PM_W)
      ) u_node (
        .pm_a    (bus.pm_in_a),
        .pm_b    (bus.pm_in_b),
        .bm_a    (bm_a_arr[gi]),
        .bm_b    (bm_b_arr[gi]),
        .norm_req(bus.norm_req),
        .pm_sel  (pm_sel[gi]),
        .dec     (dec_sel[gi])
      );
    end
  endgenerate

  // frame_start wins over in_valid; idle cycles hold metrics and decisions.
  always_comb begin
    pm_next    = pm_reg;
    dec_next   = dec_reg;
    valid_next = 1'b0;
    if (bus.frame_start) begin
      pm_next[0]  = INIT_PM0;
      pm_next[1]  = INIT_PM1;
      dec_next[0] = 1'b0;
      dec_next[1] = 1'b0;
    end else if (bus.in_valid) begin
      pm_next    = pm_sel;
      dec_next   = dec_sel;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_reg[0]  <= INIT_PM0;
      pm_reg[1]  <= INIT_PM1;
      dec_reg[0] <= 1'b0;
      dec_reg[1] <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      pm_reg     <= pm_next;
      dec_reg    <= dec_next;
      valid_reg  <= valid_next;
    end
  end

  assign bus.pm_out_0   = pm_reg[0];
  assign bus.pm_out_1   = pm_reg[1];
  assign bus.dec_0      = dec_reg[0];
  assign bus.dec_1      = dec_reg[1];
  assign bus.out_valid  = valid_reg;
  assign bus.pm_msb_and = pm_reg[0][PM_W-1] & pm_reg[1][PM_W-1];

endmodule

// File: tb/tb_acs_butterfly.sv
// Directed bench for acs_butterfly: two instances (state-0 butterfly and an ordinary one).
module tb_acs_butterfly;
  import viterbi_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  acs_butterfly_if #(.PM_W(8)) bus0 ();
  acs_butterfly_if #(.PM_W(8)) bus1 ();

  acs_butterfly #(.PM_W(8), .IS_STATE0(1'b1)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  acs_butterfly #(.PM_W(8), .IS_STATE0(1'b0)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fs, input logic nr,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] a0, input logic [1:0] b0,
                       input logic [1:0] a1, input logic [1:0] b1);
    bus0.in_valid = v;  bus0.frame_start = fs; bus0.norm_req = nr;
    bus0.pm_in_a  = a;  bus0.pm_in_b     = b;
    bus0.bm_a0    = a0; bus0.bm_b0 = b0; bus0.bm_a1 = a1; bus0.bm_b1 = b1;
    bus1.in_valid = v;  bus1.frame_start = fs; bus1.norm_req = nr;
    bus1.pm_in_a  = a;  bus1.pm_in_b     = b;
    bus1.bm_a0    = a0; bus1.bm_b0 = b0; bus1.bm_a1 = a1; bus1.bm_b1 = b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_o(input string tag, input int p0, input int d0,
                         input int p1, input int d1, input int ov);
    check({tag, ".pm_out_0"},  32'(bus0.pm_out_0),  32'(p0));
    check({tag, ".dec_0"},     32'(bus0.dec_0),     32'(d0));
    check({tag, ".pm_out_1"},  32'(bus0.pm_out_1),  32'(p1));
    check({tag, ".dec_1"},     32'(bus0.dec_1),     32'(d1));
    check({tag, ".out_valid"}, 32'(bus0.out_valid), 32'(ov));
    $display("txn %-12s pm0=%0d dec0=%0d pm1=%0d dec1=%0d ov=%0d msb=%0d", tag,
             bus0.pm_out_0, bus0.dec_0, bus0.pm_out_1, bus0.dec_1, bus0.out_valid, bus0.pm_msb_and);
  endtask

  initial begin
    drive(0, 0, 0, 8'd0, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    #12;
    check_o("reset", 0, 0, 64, 0, 0);
    check("reset.msb_and", 32'(bus0.pm_msb_and), 32'd0);
    check("reset.s1.pm_out_0", 32'(bus1.pm_out_0), 32'd64);
    check("reset.s1.pm_out_1", 32'(bus1.pm_out_1), 32'd64);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // A0=20 B0=7 -> 7 from 2j+1; A1=21 B1=7 -> 7 from 2j+1
    drive(1, 0, 0, 8'd20, 8'd5, 2'd0, 2'd2, 2'd1, 2'd2);
    tick();
    check_o("basic", 7, 1, 7, 1, 1);
    check("basic.msb_and", 32'(bus0.pm_msb_and), 32'd0);
    check("basic.s1.pm_out_0", 32'(bus1.pm_out_0), 32'd7);

    // A0=10 B0=14 -> 10; A1=12 B1=12 tie -> 12 from 2j
    drive(1, 0, 0, 8'd10, 8'd12, 2'd0, 2'd2, 2'd2, 2'd0);
    tick();
    check_o("tie", 10, 0, 12, 0, 1);

    // A0=4 B0=3 -> 3 dec 1; A1=3 B1=4 -> 3 dec 0
    drive(1, 0, 0, 8'd3, 8'd3, 2'd1, 2'd0, 2'd0, 2'd1);
    tick();
    check_o("back2back", 3, 1, 3, 0, 1);

    // Reset asserted between clock edges must take effect immediately.
    #2 rst_n = 1'b0;
    #2;
    check_o("async_rst", 0, 0, 64, 0, 0);
    check("async_rst.s1.pm_out_0", 32'(bus1.pm_out_0), 32'd64);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(1, 0, 0, 8'd20, 8'd5, 2'd0, 2'd2, 2'd1, 2'd2);
    tick();
    check_o("reload", 7, 1, 7, 1, 1);

    drive(1, 1, 0, 8'd20, 8'd5, 2'd0, 2'd2, 2'd1, 2'd2);
    tick();
    check_o("priority", 0, 0, 64, 0, 0);
    check("priority.s1.pm_out_0", 32'(bus1.pm_out_0), 32'd64);

    drive(1, 0, 0, 8'd20, 8'd5, 2'd0, 2'd2, 2'd1, 2'd2);
    tick();
    check_o("load", 7, 1, 7, 1, 1);

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 8'd99, 8'd1, 2'd3, 2'd0, 2'd3, 2'd0);
      tick();
      check_o("hold", 7, 1, 7, 1, 0);
    end

    // A=200 B=210 with zero branch metrics -> 200 from 2j, norm_req raised
    drive(1, 0, 1, 8'd200, 8'd210, 2'd0, 2'd0, 2'd0, 2'd0);
    tick();
`ifdef ACS_NORM_EN
    check_o("norm", 72, 0, 72, 0, 1);
    check("norm.msb_and", 32'(bus0.pm_msb_and), 32'd0);

    // 255+3 saturates to 255 on both sides, tie keeps A, then normalized
    drive(1, 0, 1, 8'd255, 8'd255, 2'd3, 2'd3, 2'd3, 2'd3);
    tick();
    check_o("saturate", 127, 0, 127, 0, 1);
`else
    check_o("norm_ignored", 200, 0, 200, 0, 1);
    check("norm_ignored.msb_and", 32'(bus0.pm_msb_and), 32'd1);

    // 252 vs 6: wrapped difference is negative, so 252 is the smaller metric
    drive(1, 0, 0, 8'd250, 8'd4, 2'd2, 2'd2, 2'd2, 2'd2);
    tick();
    check_o("wrap", 252, 0, 252, 0, 1);
`endif

    drive(0, 0, 0, 8'd0, 8'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
